// File: rtl/clock_period_pkg.sv
`timescale 1ns/1ps
// Clock period shared by benches for cycle/time conversion.
package clock_period_pkg;
   localparam int CLKPERIOD_NS = 10;
endpackage

// File: rtl/timer_pkg.sv
`timescale 1ns/1ps
// Shared types and default sizing for the capture timer channel.
package timer_pkg;
   typedef enum logic {IDLE, RUNNING} timer_state_t;

   localparam int TIMER_BITWIDTH_DEFAULT  = 32;
   localparam int CAPCNT_BITWIDTH_DEFAULT = 8;
endpackage

// File: rtl/capture_timer_if.sv
`timescale 1ns/1ps
// Control pulses and status outputs of one timer channel.
// master drives the pulses (BFM side), slave is the timer itself.
interface capture_timer_if #(
   parameter int TIMER_BITWIDTH  = timer_pkg::TIMER_BITWIDTH_DEFAULT,
   parameter int CAPCNT_BITWIDTH = timer_pkg::CAPCNT_BITWIDTH_DEFAULT
);
   logic                       start;
   logic                       capture;
   logic                       rst_capture;
   logic                       alarm_load;
   logic [TIMER_BITWIDTH-1:0]  alarm_time;
   logic [TIMER_BITWIDTH-1:0]  count;
   logic                       running;
   logic [TIMER_BITWIDTH-1:0]  capture_value;
   logic                       capture_valid;
   logic [CAPCNT_BITWIDTH-1:0] capture_cnt;
   logic                       alarm;
   logic                       alarm_armed;
   logic                       overflow;

   modport master (
      output start, capture, rst_capture, alarm_load, alarm_time,
      input  count, running, capture_value, capture_valid, capture_cnt,
             alarm, alarm_armed, overflow
   );

   modport slave (
      input  start, capture, rst_capture, alarm_load, alarm_time,
      output count, running, capture_value, capture_valid, capture_cnt,
             alarm, alarm_armed, overflow
   );
endinterface

// File: rtl/capture_timer.sv
`timescale 1ns/1ps
// Single timer channel: free-running counter with capture snapshots and a one-shot alarm.
// Latency: every output registered; capture_valid/alarm appear one cycle after the causing edge.
// Backpressure: none; every pulse is accepted in the cycle it is presented.
module capture_timer
   import timer_pkg::*;
#(
   parameter int TIMER_BITWIDTH  = TIMER_BITWIDTH_DEFAULT,
   parameter int CAPCNT_BITWIDTH = CAPCNT_BITWIDTH_DEFAULT
) (
   input  logic           clk,
   input  logic           areset,
   input  logic           sreset,
   capture_timer_if.slave tif
);

   localparam logic [TIMER_BITWIDTH-1:0]  CNT_MAX = '1;
   localparam logic [CAPCNT_BITWIDTH-1:0] CAP_MAX = '1;

   timer_state_t               state_q,     state_d;
   logic [TIMER_BITWIDTH-1:0]  count_q,     count_d;
   logic                       overflow_q,  overflow_d;
   logic [TIMER_BITWIDTH-1:0]  cap_value_q, cap_value_d;
   logic                       cap_valid_q, cap_valid_d;
   logic [CAPCNT_BITWIDTH-1:0] cap_cnt_q,   cap_cnt_d;
   logic [TIMER_BITWIDTH-1:0]  alarm_reg_q, alarm_reg_d;
   logic                       armed_q,     armed_d;
   logic                       alarm_q,     alarm_d;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      cap_value_d = cap_value_q;
      cap_valid_d = 1'b0;
      cap_cnt_d   = cap_cnt_q;
      alarm_reg_d = alarm_reg_q;
      armed_d     = armed_q;
      alarm_d     = 1'b0;

      if (tif.rst_capture) begin
         // Coincident capture/start/alarm_load are dropped; alarm_reg survives.
         state_d     = IDLE;
         count_d     = '0;
         overflow_d  = 1'b0;
         cap_value_d = '0;
         cap_cnt_d   = '0;
         armed_d     = 1'b0;
      end else begin
         if (tif.start) begin
            state_d    = RUNNING;
            count_d    = '0;
            overflow_d = 1'b0;
         end else if (state_q == RUNNING) begin
            count_d = count_q + 1'b1;
            if (count_q == CNT_MAX) begin
               overflow_d = 1'b1;
            end
         end

         // Snapshot uses the pre-edge count, so a capture alongside start sees the old run.
         if (tif.capture) begin
            cap_value_d = count_q;
            cap_valid_d = 1'b1;
            cap_cnt_d   = (cap_cnt_q == CAP_MAX) ? cap_cnt_q : cap_cnt_q + 1'b1;
         end

         if (tif.alarm_load) begin
            alarm_reg_d = tif.alarm_time;
            armed_d     = 1'b1;
         end else if ((state_q == RUNNING) && armed_q && (count_q == alarm_reg_q)) begin
            alarm_d = 1'b1;
            armed_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         cap_value_q <= '0;
         cap_valid_q <= 1'b0;
         cap_cnt_q   <= '0;
         alarm_reg_q <= '0;
         armed_q     <= 1'b0;
         alarm_q     <= 1'b0;
      end else if (sreset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         cap_value_q <= '0;
         cap_valid_q <= 1'b0;
         cap_cnt_q   <= '0;
         alarm_reg_q <= '0;
         armed_q     <= 1'b0;
         alarm_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         cap_value_q <= cap_value_d;
         cap_valid_q <= cap_valid_d;
         cap_cnt_q   <= cap_cnt_d;
         alarm_reg_q <= alarm_reg_d;
         armed_q     <= armed_d;
         alarm_q     <= alarm_d;
      end
   end

   assign tif.count         = count_q;
   assign tif.running       = (state_q == RUNNING);
   assign tif.capture_value = cap_value_q;
   assign tif.capture_valid = cap_valid_q;
   assign tif.capture_cnt   = cap_cnt_q;
   assign tif.alarm         = alarm_q;
   assign tif.alarm_armed   = armed_q;
   assign tif.overflow      = overflow_q;

endmodule

// File: doc/capture_timer.md
Name: capture_timer

Overview:
Single timer channel, the DUT stage directly downstream of the timer test BFM; the top level replicates it NB_INSTANCES times.
- start pulse zeroes and runs a free-running counter.
- capture pulses snapshot the counter.
- rst_capture clears captured state.
- A one-shot alarm fires when the counter reaches a programmed value.

Parameters:
TIMER_BITWIDTH, 32, width of counter, capture and alarm registers
CAPCNT_BITWIDTH, 8, width of saturating capture-event counter

Ports:
clk  in  1  single system clock, rising edge
areset  in  1  asynchronous, active-high reset
sreset  in  1  synchronous, active-high soft reset; same effect as areset, sampled on clk
start  in  1  one-cycle pulse: restart counter from 0 and enter RUNNING
capture  in  1  one-cycle pulse: snapshot counter
rst_capture  in  1  one-cycle pulse: clear captures, stop counter
alarm_load  in  1  one-cycle pulse: latch alarm_time and arm alarm
alarm_time  in  TIMER_BITWIDTH  alarm compare value in clk cycles after start
count  out  TIMER_BITWIDTH  live counter value
running  out  1  high in RUNNING
capture_value  out  TIMER_BITWIDTH  last captured count
capture_valid  out  1  one-cycle pulse, cycle after a capture is accepted
capture_cnt  out  CAPCNT_BITWIDTH  captures since last reset/rst_capture, saturating
alarm  out  1  one-cycle alarm pulse
alarm_armed  out  1  alarm loaded and not yet fired
overflow  out  1  sticky: counter wrapped in current run

Behaviour:
- Reset state (areset or sreset): state IDLE. All outputs 0, including count, capture_value, capture_cnt and alarm register.
- sreset:
  - acts on the clk edge where it is sampled high.
  - overrides every other input in that cycle.
- Priority per cycle: sreset > rst_capture > start > alarm_load/capture. alarm_load and capture are independent of each other.
- States: IDLE and RUNNING. Enumerated in the package.
  - IDLE --start--> RUNNING.
  - RUNNING --start--> RUNNING (restart).
  - any --rst_capture--> IDLE.
  - No other transitions.
- Counter:
  - The edge sampling start loads count=0.
  - Each following edge in RUNNING: count+1. count reads n exactly n cycles after the start edge.
  - IDLE holds count at its current value. rst_capture zeroes it.
  - Wrap from all-ones to 0 continues counting and sets overflow. overflow is cleared by start, rst_capture or reset.
- Capture:
  - Accepted in IDLE or RUNNING.
  - capture_value <= registered count before that edge's update. A capture coinciding with start therefore captures the old count.
  - capture_valid pulses the following cycle. capture_cnt increments, saturating at all-ones.
  - Back-to-back captures are all accepted, one per cycle.
  - rst_capture clears capture_value and capture_cnt to 0. A coincident capture is dropped.
- Alarm:
  - alarm_load latches alarm_time and sets alarm_armed. A reload while armed overwrites the value and stays armed.
  - In RUNNING with alarm_armed and count==alarm_reg: alarm=1 on the next cycle and alarm_armed clears (one-shot).
  - alarm_time=0: alarm is high 1 cycle after the start edge.
  - start does not disarm. rst_capture disarms, without clearing alarm_reg.
  - If alarm_load and a compare match occur in the same cycle, the new value wins and no alarm fires.
  - In IDLE no compare occurs. An alarm value below the current count waits for restart or wrap.
- All outputs are registered. No combinational input-to-output paths.

Decomposition:
- Package timer_pkg holds:
  - typedef enum logic {IDLE, RUNNING} timer_state_t;
  - default TIMER_BITWIDTH constant.
- Benches reuse clock_period_pkg::CLKPERIOD_NS for time conversion.
- No sub-module. A wrapper timer_array generating NB_INSTANCES copies belongs at top level, not here.

Test Plan:
- areset 100 ns, then sreset 1 cycle -> all outputs 0; state IDLE; count static over 20 cycles.
- start; 50 cycles later capture, then capture the next cycle:
  - capture_value=50, then 51.
  - capture_valid is high for 2 consecutive cycles.
  - capture_cnt=2.
- start, wait 500 cycles, rst_capture:
  - count=0, running=0, capture_cnt=0.
  - start again; capture 181 cycles later -> capture_value=181.
- alarm_load with alarm_time=1000, start -> alarm high for exactly 1 cycle, 1001 cycles after the start edge; alarm_armed=0 afterwards; no second alarm after a further 2000 cycles.
- Boundary cases:
  - alarm_time=0 -> alarm 1 cycle after start.
  - capture coincident with start at count=37 -> capture_value=37, count=0.
  - TIMER_BITWIDTH=8 run for 300 cycles -> overflow=1, count=44.
- Randomized: 10 runs with random 16-bit capture delays and alarm times, checked against a reference model.
